// File: rtl/mux_pkg.sv
// mux_pkg: shared mode constants and index-width helper for the round-robin mux.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_n_rr_grant.sv
// rr_grant: combinational round-robin picker, first request at or above ptr with wrap.
module rr_grant
    import mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] c;

    // Scan from the farthest offset down so the closest request to ptr wins last.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            c = W'((int'(ptr) + i) % N);
            if (req[c]) begin
                gnt    = '0;
                gnt[c] = 1'b1;
                idx    = c;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_n.sv
// mux_rr_n: registered N-channel valid/ready merge with fixed-select or round-robin grant.
module mux_rr_n
    import mux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int CH_W     = idx_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [CH_W-1:0]           select,
    input  logic [CHANNELS-1:0]       inValid,
    input  logic [CHANNELS*WIDTH-1:0] inData,
    output logic [CHANNELS-1:0]       inReady,
    output logic                      outValid,
    output logic [WIDTH-1:0]          outData,
    output logic [CH_W-1:0]           outChannel,
    input  logic                      outReady
);

    logic                can_load, grant_any, xfer, rr_any;
    logic [CH_W-1:0]     grant_idx, rr_idx;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d, out_channel_q, out_channel_d;
    logic [CHANNELS-1:0] rr_gnt;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;

    rr_grant #(.N(CHANNELS), .W(CH_W)) u_rr (
        .req (inValid),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    always_comb begin
        can_load      = !out_valid_q || outReady;
        grant_idx     = (mode == MODE_RR) ? rr_idx : select;
        grant_any     = (mode == MODE_RR) ? rr_any : (int'(select) < CHANNELS);
        inReady       = (!reset && can_load && grant_any)
                        ? ((mode == MODE_RR) ? rr_gnt : (CHANNELS'(1) << select)) : '0;
        xfer          = |(inValid & inReady);
        out_valid_d   = xfer || (out_valid_q && !outReady);
        out_data_d    = xfer ? inData[int'(grant_idx)*WIDTH +: WIDTH] : out_data_q;
        out_channel_d = xfer ? grant_idx : out_channel_q;
        rr_ptr_d      = (xfer && mode == MODE_RR)
                        ? ((int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1) : rr_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            rr_ptr_q      <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign outValid   = out_valid_q;
    assign outData    = out_data_q;
    assign outChannel = out_channel_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: directed and randomized checks of mux_rr_n against a behavioural model.
module tb_mux_rr_n;
    import mux_pkg::*;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 0, reset = 1, mode = 0, out_ready = 0;
    logic [1:0]     sel = 0;
    logic [N-1:0]   in_valid = 0, in_ready;
    logic [N*W-1:0] in_data = 0;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_channel;

    logic [2:0]     in_ready3;
    logic           out_valid3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_channel3;

    int             checks = 0, errors = 0;
    bit             m_valid;
    logic [W-1:0]   m_data;
    int             m_ch, m_ptr;
    logic [N-1:0]   last_acc = 0;

    always #5 clk = ~clk;

    mux_rr_n #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk(clk), .reset(reset), .mode(mode), .select(sel),
        .inValid(in_valid), .inData(in_data), .inReady(in_ready),
        .outValid(out_valid), .outData(out_data), .outChannel(out_channel),
        .outReady(out_ready)
    );

    mux_rr_n #(.WIDTH(W), .CHANNELS(3)) dut3 (
        .clk(clk), .reset(reset), .mode(MODE_FIXED), .select(2'd3),
        .inValid(3'b111), .inData(48'h3333_2222_1111), .inReady(in_ready3),
        .outValid(out_valid3), .outData(out_data3), .outChannel(out_channel3),
        .outReady(1'b1)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int grant_of();
        if (mode == MODE_FIXED) return (int'(sel) < N) ? int'(sel) : -1;
        for (int k = 0; k < N; k++)
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g = grant_of();
        if (reset || (m_valid && !out_ready) || g < 0) return '0;
        return 4'(1) << g;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_data  = 0;
        m_ch    = 0;
        m_ptr   = 0;
    endtask

    task automatic cycle();
        logic [N-1:0] er;
        int g;
        #1;
        er = exp_ready();
        g  = grant_of();
        check("in_ready", in_ready, er);
        @(posedge clk);
        if (er != 0 && in_valid[g]) begin
            m_valid = 1;
            m_data  = in_data[g*W +: W];
            m_ch    = g;
            if (mode == MODE_RR) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_channel", out_channel, m_ch);
        last_acc = in_valid & er;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        out_ready = 1;
        in_valid  = 4'hf;
        mode      = MODE_RR;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 0);
        check("rst_ready3", in_ready3, 0);
        @(negedge clk);
        reset = 0;

        mode = MODE_FIXED;
        sel = 2;
        in_valid = 4'b0100;
        in_data[2*W +: W] = 16'h1234;
        #1;
        check("fx_ready", in_ready, 4'b0100);
        cycle();
        check("fx_valid", out_valid, 1);
        check("fx_data", out_data, 16'h1234);
        check("fx_chan", out_channel, 2);
        in_valid = 0;
        cycle();
        check("fx_empty", out_valid, 0);

        check("oor_ready3", in_ready3, 0);
        check("oor_valid3", out_valid3, 0);

        mode = MODE_RR;
        in_valid = 4'hf;
        for (int k = 0; k < N; k++) in_data[k*W +: W] = 16'hA000 + 16'(k);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_chan", out_channel, i % N);
            check("rr_data", out_data, 16'hA000 + 16'(i % N));
            check("rr_valid", out_valid, 1);
        end

        in_valid = 4'b0001;
        cycle();
        in_valid = 4'b1001;
        cycle();
        check("skip_3", out_channel, 3);
        cycle();
        check("skip_0", out_channel, 0);
        in_valid = 4'b1111;
        cycle();
        check("skip_ptr", out_channel, 1);

        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_ready", in_ready, 0);
            check("bp_chan", out_channel, 1);
            check("bp_data", out_data, 16'hA001);
        end
        out_ready = 1;
        mode = MODE_FIXED;
        sel = 2;
        in_valid = 4'b0100;
        in_data[2*W +: W] = 16'hBEEF;
        cycle();
        check("bp_refill_v", out_valid, 1);
        check("bp_refill_d", out_data, 16'hBEEF);

        mode = MODE_RR;
        in_valid = 4'hf;
        cycle();
        cycle();
        #2;
        reset = 1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_chan", out_channel, 0);
        check("arst_ready", in_ready, 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        cycle();
        check("arst_ptr", out_channel, 0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) mode = ~mode;
            if ($urandom_range(7) == 0) sel = 2'($urandom);
            for (int k = 0; k < N; k++) begin
                if (!in_valid[k] || last_acc[k]) begin
                    in_valid[k] = 1'($urandom);
                    in_data[k*W +: W] = 16'($urandom);
                end
            end
            out_ready = ($urandom_range(3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Parametrised, registered N-channel multiplexer with a valid/ready handshake and two selection modes: fixed (explicit `select`) and round-robin among requesting channels. It generalises the 2:1 8-bit combinational mux into a flow-controlled merge stage. The stage funnels several word producers into one consumer with one cycle of latency and fair arbitration. The output carries the data word and the index of the channel it came from.

## Interface
- `WIDTH`, 16: data word width in bits (≥1).
- `CHANNELS`, 4: number of input channels (≥2).
- `CH_W`, derived, max(1, clog2(CHANNELS)): width of channel indices; not overridden.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `mode`  in  1: 0 = fixed select, 1 = round-robin.
- `select`  in  CH_W: channel index used in fixed mode; ignored in round-robin mode.
- `inValid`  in  CHANNELS: per-channel valid.
- `inData`  in  CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `inReady`  out  CHANNELS: per-channel ready; one-hot or zero.
- `outValid`  out  1: output register holds a beat.
- `outData`  out  WIDTH: registered data.
- `outChannel`  out  CH_W: source channel of the current output beat.
- `outReady`  in  1: consumer accepts the beat.

## Operation
- Output register state is EMPTY (`outValid`=0) or FULL (`outValid`=1).
- `canLoad` = !outValid || outReady. This gives full throughput: one beat per cycle while the consumer is ready.
- Grant selection (combinational):
  - **Fixed mode:** the candidate is `select`. If `select` ≥ CHANNELS, there is no grant and `inReady` is all zero.
  - **Round-robin mode:** the candidate is the first channel with `inValid` set, scanning upward from `rrPtr` and wrapping CHANNELS-1 → 0.
- `inReady[g]` = canLoad for the candidate g. In fixed mode this holds regardless of `inValid[g]`. All other bits are 0.
- A transfer on channel g occurs when `inValid[g] && inReady[g]`. On the next edge, the register loads `outData`←inData[g], `outChannel`←g and `outValid`←1.
- If outReady=1 and there is no transfer, `outValid`←0. `outData` and `outChannel` hold their last values.
- If outValid=1 and outReady=0, the register holds; all `inReady` are 0.
- `rrPtr` (CH_W bits) advances to (g+1) mod CHANNELS only on a transfer in round-robin mode. Fixed-mode transfers do not move it.
- A `mode` or `select` change takes effect on the same cycle's grant. A beat already in the register is unaffected.
- Producers must hold `inValid`/`inData` stable until accepted. The block does not check this.

## Timing
- Reset values (asynchronous, immediate): outValid=0, outData=0, outChannel=0, rrPtr=0.
- While reset is asserted, `inReady` is all zero.
- Reset mid-transfer discards the held beat.
- Latency is 1 cycle from an accepting edge to outValid=1.
- `inReady` depends combinationally on `outReady`, `mode`, `select`, `inValid` and `rrPtr`. There are no other combinational input→output paths.
- Simultaneous drain and load (FULL, outReady=1, transfer) replaces the beat in place. `outValid` stays 1.
- Round-robin wrap: if rrPtr=CHANNELS-1 and channel CHANNELS-1 transfers, then rrPtr becomes 0.
- Round-robin with no valid channel gives no grant; rrPtr is unchanged.

## Structure
- Shared package `mux_pkg`:
  - Mode constants: MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Index-width helper function.
- Sub-module `rr_grant` (combinational): takes the request vector and the pointer, and produces a one-hot grant and an encoded index plus an any-grant flag. It is instantiated once, for round-robin mode.
- The top level holds the output register, rrPtr, the mode mux and the ready logic.

## Test plan
Tests use WIDTH=16, CHANNELS=4.
- **Reset:** assert `reset` mid-run with outValid=1 → outValid, outData, outChannel and rrPtr read 0 immediately, and inReady=0000 during reset.
- **Fixed mode basics:** mode=0, select=2, inValid=0100, inData[2]=16'h1234, outReady=1 → inReady=0100. Next cycle: outValid=1, outData=16'h1234, outChannel=2. With no new valid and outReady=1, outValid returns to 0 the following cycle.
- **Fixed mode, out-of-range select:** mode=0 with CHANNELS=3, select=3, all valid → inReady=000 and outValid stays 0.
- **Round-robin fairness:** mode=1, all four valid continuously, data = 16'hA000+k, outReady=1 → outChannel sequence 0,1,2,3,0,1 with one beat per cycle and pointer wrap verified.
- **Round-robin skip:** rrPtr=1, inValid=1001 → grants 3 then 0, and rrPtr goes 1→0→1.
- **Backpressure:** register FULL with outReady=0 for 5 cycles → outData/outChannel are stable and inReady=0000. Then outReady=1 with a channel valid → drain and load occur on the same edge and outValid stays 1.
